// File: rtl/exec_mem_responder.sv
// Multi-port memory responder: round-robin arbitration, one access per cycle,
// fixed-latency read return and a self-initialising array filled after reset.
module exec_mem_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 4096,
  parameter int NUM_PORTS  = 2,
  parameter int RD_LATENCY = 1,
  parameter int INIT_MODE  = 1,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = 'o7402
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_PORTS-1:0]             req_rd,
  input  logic [NUM_PORTS-1:0]             req_wr,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_gnt,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_data,
  output logic                             init_done,
  output logic                             err_oob,
  output logic                             err_rdwr,
  output logic [15:0]                      rd_count,
  output logic [15:0]                      wr_count
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [MEM_AW-1:0]   LAST_WORD = MEM_AW'(DEPTH-1);
  localparam logic [PTR_W-1:0]    LAST_PORT = PTR_W'(NUM_PORTS-1);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                  state_q;
  logic [MEM_AW-1:0]       initAddr_q;
  logic                    initDone_q;
  logic [PTR_W-1:0]        ptr_q;
  logic [PTR_W-1:0]        ptr_d;
  logic                    errOob_q;
  logic                    errRdwr_q;
  logic [15:0]             rdCount_q;
  logic [15:0]             wrCount_q;

  logic                    pipeValid_q [RD_LATENCY];
  logic [PTR_W-1:0]        pipePort_q  [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   pipeData_q  [RD_LATENCY];

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    gntAny;
  logic [PTR_W-1:0]        gntPort;
  logic [PTR_W-1:0]        candPort;
  logic                    gntRd;
  logic                    gntWr;
  logic                    gntBoth;
  logic [ADDR_WIDTH-1:0]   gntAddr;
  logic [DATA_WIDTH-1:0]   gntWdata;
  logic                    gntOob;
  logic [MEM_AW-1:0]       memIdx;
  logic [DATA_WIDTH-1:0]   rdData;
  logic [DATA_WIDTH-1:0]   fillWord;
  logic                    memWe;
  logic [MEM_AW-1:0]       memWaddr;
  logic [DATA_WIDTH-1:0]   memWdata;

  // Round-robin search starting at the pointer; only active once the fill is done.
  always_comb begin
    gntAny   = 1'b0;
    gntPort  = ptr_q;
    candPort = '0;
    req_gnt  = '0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        candPort = PTR_W'((int'(ptr_q) + i) % NUM_PORTS);
        if (!gntAny && (req_rd[candPort] || req_wr[candPort])) begin
          gntAny  = 1'b1;
          gntPort = candPort;
        end
      end
      if (gntAny) begin
        req_gnt[gntPort] = 1'b1;
      end
    end
  end

  always_comb begin
    gntAddr  = req_addr[gntPort*ADDR_WIDTH +: ADDR_WIDTH];
    gntWdata = req_wdata[gntPort*DATA_WIDTH +: DATA_WIDTH];
    gntWr    = gntAny && req_wr[gntPort];
    gntBoth  = gntAny && req_wr[gntPort] && req_rd[gntPort];
    gntRd    = gntAny && req_rd[gntPort] && !req_wr[gntPort];
    gntOob   = {1'b0, gntAddr} >= DEPTH_EXT;
    memIdx   = gntAddr[MEM_AW-1:0];
    rdData   = gntOob ? '0 : mem[memIdx];
    ptr_d    = ptr_q;
    if (gntAny) begin
      ptr_d = (gntPort == LAST_PORT) ? '0 : gntPort + 1'b1;
    end
  end

  always_comb begin
    case (INIT_MODE)
      1:       fillWord = DATA_WIDTH'(initAddr_q);
      2:       fillWord = FILL_VALUE;
      default: fillWord = '0;
    endcase
  end

  // The fill owns the write port during INIT; afterwards only in-range granted writes use it.
  always_comb begin
    if (state_q == ST_INIT) begin
      memWe    = 1'b1;
      memWaddr = initAddr_q;
      memWdata = fillWord;
    end else begin
      memWe    = gntWr && !gntOob;
      memWaddr = memIdx;
      memWdata = gntWdata;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memWaddr] <= memWdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      initAddr_q <= '0;
      initDone_q <= 1'b0;
      ptr_q      <= '0;
      errOob_q   <= 1'b0;
      errRdwr_q  <= 1'b0;
      rdCount_q  <= '0;
      wrCount_q  <= '0;
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipeValid_q[s] <= 1'b0;
        pipePort_q[s]  <= '0;
        pipeData_q[s]  <= '0;
      end
    end else begin
      for (int s = RD_LATENCY-1; s > 0; s--) begin
        pipeValid_q[s] <= pipeValid_q[s-1];
        pipePort_q[s]  <= pipePort_q[s-1];
        pipeData_q[s]  <= pipeData_q[s-1];
      end
      pipeValid_q[0] <= gntRd;
      pipePort_q[0]  <= gntPort;
      pipeData_q[0]  <= rdData;
      ptr_q          <= ptr_d;
      case (state_q)
        ST_INIT: begin
          initAddr_q <= initAddr_q + 1'b1;
          if (initAddr_q == LAST_WORD) begin
            initAddr_q <= '0;
            state_q    <= ST_RUN;
            initDone_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (gntRd) begin
            rdCount_q <= rdCount_q + 16'd1;
          end
          if (gntWr) begin
            wrCount_q <= wrCount_q + 16'd1;
          end
          if (gntAny && gntOob) begin
            errOob_q <= 1'b1;
          end
          if (gntBoth) begin
            errRdwr_q <= 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (pipeValid_q[RD_LATENCY-1]) begin
      rsp_valid[pipePort_q[RD_LATENCY-1]] = 1'b1;
      rsp_data[pipePort_q[RD_LATENCY-1]*DATA_WIDTH +: DATA_WIDTH] = pipeData_q[RD_LATENCY-1];
    end
  end

  assign init_done = initDone_q;
  assign err_oob   = errOob_q;
  assign err_rdwr  = errRdwr_q;
  assign rd_count  = rdCount_q;
  assign wr_count  = wrCount_q;

endmodule
